// File: rtl/crd_rd_arb.sv
// crd_rd_arb: two-requester arbiter on the GLB coordinate read port.
// Requester 0 is the FPS loop and requester 1 is the KNN/sort fetch.
// Addresses are granted round-robin, one per cycle.
// Each accepted winner id is queued in an in-order tag FIFO.
// Returning data is steered to the requester at the FIFO head.
// Address and data paths are combinational, so the block adds zero cycles.
// Optional macro CRD_RD_ARB_FPS_PRIO_EN switches to fixed priority (R0 always wins).
module crd_rd_arb #(
    parameter int unsigned IDX_WIDTH    = 10,
    parameter int unsigned SRAM_WIDTH   = 256,
    parameter int unsigned OUTSTD_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [IDX_WIDTH-1:0]  R0_Addr,
    input  logic                  R0_AddrVld,
    output logic                  R0_AddrRdy,
    input  logic [IDX_WIDTH-1:0]  R1_Addr,
    input  logic                  R1_AddrVld,
    output logic                  R1_AddrRdy,
    output logic [SRAM_WIDTH-1:0] R0_Dat,
    output logic                  R0_DatVld,
    input  logic                  R0_DatRdy,
    output logic [SRAM_WIDTH-1:0] R1_Dat,
    output logic                  R1_DatVld,
    input  logic                  R1_DatRdy,
    output logic [IDX_WIDTH-1:0]  ARBGLB_Addr,
    output logic                  ARBGLB_AddrVld,
    input  logic                  GLBARB_AddrRdy,
    input  logic [SRAM_WIDTH-1:0] GLBARB_Dat,
    input  logic                  GLBARB_DatVld,
    output logic                  ARBGLB_DatRdy,
    output logic                  Err
);

    localparam int unsigned PTR_W = $clog2(OUTSTD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [OUTSTD_DEPTH-1:0] tag_q;
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    last_q;
    logic                    err_q;

    logic full;
    logic busy;
    logic head;
    logic win;
    logic gnt;
    logic push;
    logic pop;
    logic stray;

    // Pick a winner among valid requesters; full is judged on the registered count only.
    always_comb begin
        win  = 1'b0;
        gnt  = 1'b0;
        full = (cnt_q == CNT_W'(OUTSTD_DEPTH));
`ifdef CRD_RD_ARB_FPS_PRIO_EN
        win = ~R0_AddrVld;
`else
        if (R0_AddrVld && R1_AddrVld) begin
            win = ~last_q;
        end else begin
            win = R1_AddrVld;
        end
`endif
        gnt = (R0_AddrVld | R1_AddrVld) & ~full;
    end

    // Forward the winner's address to the GLB and hand GLB ready back to the winner.
    always_comb begin
        ARBGLB_AddrVld = gnt;
        ARBGLB_Addr    = '0;
        if (gnt) begin
            ARBGLB_Addr = win ? R1_Addr : R0_Addr;
        end
        R0_AddrRdy = gnt & ~win & GLBARB_AddrRdy;
        R1_AddrRdy = gnt &  win & GLBARB_AddrRdy;
        push       = gnt & GLBARB_AddrRdy;
    end

    // Steer returning data to the head-tag owner; with nothing outstanding, sink and flag it.
    always_comb begin
        busy          = (cnt_q != '0);
        head          = tag_q[rd_ptr_q];
        R0_Dat        = '0;
        R0_DatVld     = 1'b0;
        R1_Dat        = '0;
        R1_DatVld     = 1'b0;
        ARBGLB_DatRdy = 1'b1;
        if (busy) begin
            ARBGLB_DatRdy = head ? R1_DatRdy : R0_DatRdy;
            if (head) begin
                R1_Dat    = GLBARB_Dat;
                R1_DatVld = GLBARB_DatVld;
            end else begin
                R0_Dat    = GLBARB_Dat;
                R0_DatVld = GLBARB_DatVld;
            end
        end
        pop   = busy & GLBARB_DatVld & ARBGLB_DatRdy;
        stray = ~busy & GLBARB_DatVld;
    end

    // Tag FIFO, occupancy count, round-robin pointer and sticky error; clr overrides push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            err_q    <= 1'b0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= win;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                last_q          <= win;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (stray) begin
                err_q <= 1'b1;
            end
        end
    end

    assign Err = err_q;

endmodule
